// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bits needed to count 0..w-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full-adder cell: two half adders plus an OR for the carry.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s1;
    logic c1;
    logic c2;

    serial_half_adder u_ha0 (
        .a (a),
        .b (b),
        .s (s1),
        .c (c1)
    );

    serial_half_adder u_ha1 (
        .a (s1),
        .b (ci),
        .s (s),
        .c (c2)
    );

    // Only one of the two half-adder carries can be set at a time.
    always_comb begin
        co = c1 | c2;
    end

endmodule

// File: rtl/serial_half_adder.sv
// Combinational half adder: building block of the serial full-adder cell.
module serial_half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    // Sum and carry of two single bits.
    always_comb begin
        s = a ^ b;
        c = a & b;
    end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: captures a, b, cin on start and produces
// {cout,sum} = a + b + cin one bit per cycle, LSB first.
// Optional feature: define SERIAL_ADD_CTRL_OVF_EN to add the signed overflow
// output ovf, registered alongside cout.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_CTRL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned   CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    serial_fa_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Controller FSM with registered status outputs and the serial datapath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADD_CTRL_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    // sum/cout keep the previous result until bits start arriving.
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= fa_co;
                    // New bit enters at the MSB; after WIDTH shifts bit 0 is in place.
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    if (cnt == LAST) begin
                        cout  <= fa_co;
`ifdef SERIAL_ADD_CTRL_OVF_EN
                        // carry holds the carry into the MSB on this cycle.
                        ovf   <= carry ^ fa_co;
`endif
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed vectors,
// random operands, mid-run disturbance, reset abort and back-to-back starts.
module tb_serial_add_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_CTRL_OVF_EN
    logic         ovf;
`endif

    int errors = 0;
    int checks = 0;

    serial_add_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_CTRL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer addition, and signed overflow from operand/result signs.
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic c);
        logic [W:0] r;
        r = ref_add(x, y, c);
        return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    endfunction

    // Called at a negedge in IDLE. Runs one addition and returns at the negedge
    // where IDLE is reached again. Inputs are scrambled after capture.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input bit disturb);
        int         busy_cnt;
        int         done_cnt;
        logic [W:0] exp;
        exp = ref_add(ta, tb, tc);
        check_eq("ready_before_start", ready, 1'b1);
        a     = ta;
        b     = tb;
        cin   = tc;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < W + 2; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                check_eq("sum", sum, exp[W-1:0]);
                check_eq("cout", cout, exp[W]);
`ifdef SERIAL_ADD_CTRL_OVF_EN
                check_eq("ovf", ovf, ref_ovf(ta, tb, tc));
`endif
            end
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            if (disturb) start = (i == 2);
            if (i < W + 1) @(negedge clk);
        end
        start = 1'b0;
        check_eq("busy_cycles", busy_cnt, W);
        check_eq("done_cycles", done_cnt, 1);
        check_eq("ready_after", ready, 1'b1);
        check_eq("busy_after", busy, 1'b0);
        check_eq("sum_held", {cout, sum}, exp);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_ready"}, ready, 1'b1);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_sum"}, {cout, sum}, '0);
`ifdef SERIAL_ADD_CTRL_OVF_EN
        check_eq({tag, "_ovf"}, ovf, 1'b0);
`endif
    endtask

    logic [W:0] exp_q[$];
    logic       ovf_q[$];

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        int           k;
        int           d;
        int           last_done;
        bit           seen_done;

        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors.
        do_op(8'h0F, 8'h01, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 1'b1, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 1'b0);
        do_op(8'h80, 8'h80, 1'b1, 1'b0);
        // Extra start and changing operands mid-run must be ignored.
        do_op(8'h3C, 8'h5A, 1'b1, 1'b1);

        // Random operands.
        for (int n = 0; n < 20; n++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), (n % 4) == 0);
        end

        // Reset during RUN: immediate clear, no later done pulse.
        a     = 8'hAA;
        b     = 8'h55;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("busy_before_abort", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("abort");
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) seen_done = 1'b1;
        end
        rst_n = 1'b1;
        // First start right after deassertion must be accepted and complete.
        do_op(8'h12, 8'h34, 1'b0, 1'b0);
        check_eq("no_done_after_abort", seen_done, 1'b0);

        // Start held high: three operations, done pulses W+2 cycles apart.
        k         = 0;
        d         = 0;
        last_done = 0;
        start     = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (done) begin
                if (exp_q.size() > 0) begin
                    check_eq("b2b_sum", {cout, sum}, exp_q.pop_front());
`ifdef SERIAL_ADD_CTRL_OVF_EN
                    check_eq("b2b_ovf", ovf, ovf_q.pop_front());
`else
                    void'(ovf_q.pop_front());
`endif
                end
                if (d > 0) check_eq("b2b_spacing", cyc - last_done, W + 2);
                last_done = cyc;
                d++;
            end
            if (ready) begin
                if (k < 3) begin
                    ra  = W'($urandom);
                    rb  = W'($urandom);
                    rc  = 1'($urandom);
                    a   = ra;
                    b   = rb;
                    cin = rc;
                    exp_q.push_back(ref_add(ra, rb, rc));
                    ovf_q.push_back(ref_ovf(ra, rb, rc));
                    k++;
                end else begin
                    start = 1'b0;
                end
            end
            if (d == 3 && start == 1'b0) break;
            @(negedge clk);
        end
        start = 1'b0;
        check_eq("b2b_done_count", d, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so a stuck design still ends with a summary.
    initial begin
        #200000;
        errors++;
        checks++;
        $display("FAIL timeout: got=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, is the operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  is the sole clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  is the reset; it is asynchronous and active-low.
REQ-004 Port: start  input  1  is the request to begin an addition; it is sampled only when ready=1.
REQ-005 Port: a  input  WIDTH  is operand A, captured on the accepted start.
REQ-006 Port: b  input  WIDTH  is operand B, captured on the accepted start.
REQ-007 Port: cin  input  1  is the carry-in, captured on the accepted start.
REQ-008 Port: ready  output  1  is high only in IDLE.
REQ-009 Port: busy  output  1  is high only in RUN.
REQ-010 Port: done  output  1  is a one-cycle pulse marking a valid result.
REQ-011 Port: sum  output  WIDTH  is the result register; it holds its value until the next accepted start.
REQ-012 Port: cout  output  1  is the final carry; it is held like sum.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE -> RUN when start=1; on that edge, a, b and cin are captured into shift registers, the bit counter is set to 0, and sum/cout are left unchanged.
REQ-015 RUN SHALL process one bit per cycle, LSB first, through a single full-adder cell.
  - Each bit: sum bit i = a_i ^ b_i ^ c, carry = majority.
  - The carry register is updated every cycle.
REQ-016 RUN -> DONE after exactly WIDTH cycles, i.e. on the edge where counter = WIDTH-1.
  - On that edge, sum is fully written and cout gets the final carry.
REQ-017 DONE SHALL last exactly one cycle with done=1, then go unconditionally to IDLE.
REQ-018 Latency: if start is accepted at edge 0, done is high during the cycle after edge WIDTH+1... precisely, done=1 for the single cycle following edge WIDTH, and ready=1 again after edge WIDTH+1.
REQ-019 start while busy=1 or done=1 SHALL be ignored, with no queuing.
REQ-020 a, b and cin changing after capture SHALL not affect the result.
REQ-021 Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1), with no truncation.
REQ-022 Back-to-back: start held high continuously SHALL yield one addition every WIDTH+2 cycles.

Reset
REQ-023 rst_n=0 SHALL force the following immediately, regardless of clk:
  - state = IDLE
  - ready=1, busy=0, done=0
  - sum=0, cout=0
  - counter and carry cleared
REQ-024 Reset asserted mid-RUN SHALL abort the operation; no done pulse is produced afterwards.
REQ-025 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-026 Macro SERIAL_ADD_CTRL_OVF_EN, when defined, SHALL add the port ovf  output  1.
  - ovf is the signed overflow: carry into MSB XOR carry out of MSB.
  - It is registered with cout and reset to 0.
REQ-027 Without SERIAL_ADD_CTRL_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-028 Package serial_add_pkg SHALL hold:
  - the state enum (IDLE, RUN, DONE)
  - the default WIDTH constant
  - the counter-width function/constant, clog2(WIDTH)
REQ-029 The bit-level adder SHALL be a sub-module, serial_fa_cell.
  - It is built from two half-adder instances plus an OR for the carry.
  - It is purely combinational; the controller holds all state.

Verification (WIDTH=8)
REQ-030 Reset, then start with a=8'h0F, b=8'h01, cin=0 -> busy for 8 cycles, done pulse for 1 cycle, sum=8'h10, cout=0.
REQ-031 a=8'hFF, b=8'h01, cin=1 -> sum=8'h01, cout=1; with OVF_EN, ovf=0.
REQ-032 a=8'h7F, b=8'h01, cin=0 with OVF_EN -> sum=8'h80, cout=0, ovf=1.
REQ-033 Pulse start again at cycle 3 of RUN and change a/b mid-RUN -> request ignored, result equals the originally captured operands.
REQ-034 rst_n low at cycle 4 of RUN -> outputs go to reset values immediately, no done pulse, next start completes normally.
REQ-035 start held high for 3 operations -> done pulses 10 cycles apart, each sum correct.
